// File: rtl/ucie_ctl_rx_fdi_fifo_pkg.sv
// Shared definitions for the controller RX path: link state-request
// encodings and the RX FDI FIFO control FSM state type.
package ucie_ctl_rx_fdi_fifo_pkg;

  localparam logic [3:0] STATE_REQ_RESET  = 4'b0000;
  localparam logic [3:0] STATE_REQ_ACTIVE = 4'b0001;

  typedef enum logic [1:0] {
    FIFO_IDLE   = 2'd0,
    FIFO_ACTIVE = 2'd1,
    FIFO_DRAIN  = 2'd2,
    FIFO_ERROR  = 2'd3
  } fifo_state_e;

  function automatic logic is_active_req(input logic [3:0] req);
    return req == STATE_REQ_ACTIVE;
  endfunction

  function automatic logic is_reset_req(input logic [3:0] req);
    return req == STATE_REQ_RESET;
  endfunction

endpackage

// File: rtl/ucie_ctl_rx_fdi_fifo_if.sv
// FDI stream in, protocol-layer ready/valid out, plus credit/status.
interface ucie_ctl_rx_fdi_fifo_if #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned DEPTH  = 4
) ();

  logic [3:0]                   i_state_request;
  logic [NBYTES*8-1:0]          i_fdi_data;
  logic                         i_fdi_data_valid;
  logic                         i_pl_ready;
  logic [NBYTES*8-1:0]          o_pl_data;
  logic                         o_pl_valid;
  logic                         o_credit_return;
  logic [$clog2(DEPTH+1)-1:0]   o_count;
  logic                         o_overflow;

  // FIFO side
  modport slave (
    input  i_state_request, i_fdi_data, i_fdi_data_valid, i_pl_ready,
    output o_pl_data, o_pl_valid, o_credit_return, o_count, o_overflow
  );

  // Environment side (RX buffer + protocol layer)
  modport master (
    output i_state_request, i_fdi_data, i_fdi_data_valid, i_pl_ready,
    input  o_pl_data, o_pl_valid, o_credit_return, o_count, o_overflow
  );

endinterface

// File: rtl/ucie_ctl_sync_fifo.sv
// First-word-fall-through synchronous FIFO with explicit occupancy counter,
// flush, and overflow detect (push while full without a same-cycle pop).
module ucie_ctl_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wr_data,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [$clog2(DEPTH+1)-1:0] o_count_next,
  output logic                       o_empty,
  output logic                       o_overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic full;
  logic do_push;
  logic do_pop;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign o_empty    = (count_q == '0);
  assign do_pop     = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push    = i_push && (!full || do_pop) && !i_flush;
  assign o_overflow = i_push && full && !do_pop;

  assign o_rd_data    = mem[rd_ptr_q];
  assign o_count      = count_q;
  assign o_count_next = count_d;

  // Next pointers and occupancy; flush wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_q] <= i_wr_data;
  end

endmodule

// File: rtl/ucie_ctl_rx_fdi_fifo.sv
// RX FDI FIFO wrapper: link-state gating FSM (IDLE/ACTIVE/DRAIN/ERROR),
// credit return register, and the FWFT FIFO that absorbs PL back-pressure.
module ucie_ctl_rx_fdi_fifo
  import ucie_ctl_rx_fdi_fifo_pkg::*;
#(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned DEPTH  = 4
) (
  input logic                     i_clk,
  input logic                     i_rst,
  ucie_ctl_rx_fdi_fifo_if.slave   fdi
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  fifo_state_e state_q, state_d;
  logic        overflow_q, overflow_d;
  logic        credit_q, credit_d;

  logic             fifo_empty;
  logic             fifo_ovf;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] fifo_count_next;
  logic             pl_valid;
  logic             push;
  logic             pop;
  logic             flush;

  assign pl_valid = !fifo_empty && (state_q == FIFO_ACTIVE || state_q == FIFO_DRAIN);
  assign pop      = pl_valid && fdi.i_pl_ready;
  assign push     = fdi.i_fdi_data_valid && (state_q == FIFO_ACTIVE);
  // Flushing in the overflow cycle makes ERROR start with an empty FIFO.
  assign flush    = fifo_ovf || (state_q == FIFO_ERROR);

  ucie_ctl_sync_fifo #(
    .WIDTH (NBYTES*8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (flush),
    .i_push       (push),
    .i_pop        (pop),
    .i_wr_data    (fdi.i_fdi_data),
    .o_rd_data    (fdi.o_pl_data),
    .o_count      (fifo_count),
    .o_count_next (fifo_count_next),
    .o_empty      (fifo_empty),
    .o_overflow   (fifo_ovf)
  );

  // Next state, sticky overflow and credit; exit decisions use post-edge
  // occupancy so a push in the leaving cycle is drained, not stranded.
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    credit_d   = pop;
    case (state_q)
      FIFO_IDLE: begin
        if (is_active_req(fdi.i_state_request)) state_d = FIFO_ACTIVE;
      end
      FIFO_ACTIVE: begin
        if (fifo_ovf) begin
          state_d    = FIFO_ERROR;
          overflow_d = 1'b1;
        end else if (!is_active_req(fdi.i_state_request)) begin
          state_d = (fifo_count_next != '0) ? FIFO_DRAIN : FIFO_IDLE;
        end
      end
      FIFO_DRAIN: begin
        if (is_active_req(fdi.i_state_request)) state_d = FIFO_ACTIVE;
        else if (fifo_count_next == '0)         state_d = FIFO_IDLE;
      end
      FIFO_ERROR: begin
        if (is_reset_req(fdi.i_state_request)) begin
          state_d    = FIFO_IDLE;
          overflow_d = 1'b0;
        end
      end
      default: state_d = FIFO_IDLE;
    endcase
  end

  // FSM and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= FIFO_IDLE;
      overflow_q <= 1'b0;
      credit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      credit_q   <= credit_d;
    end
  end

  assign fdi.o_pl_valid      = pl_valid;
  assign fdi.o_credit_return = credit_q;
  assign fdi.o_count         = fifo_count;
  assign fdi.o_overflow      = overflow_q;

endmodule

// File: tb/tb_ucie_ctl_rx_fdi_fifo.sv
// Bench for ucie_ctl_rx_fdi_fifo: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_ucie_ctl_rx_fdi_fifo;

  localparam int unsigned NB = 4;
  localparam int unsigned DP = 4;
  localparam int unsigned W  = NB*8;

  localparam int M_IDLE  = 0;
  localparam int M_ACT   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_ERR   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ucie_ctl_rx_fdi_fifo_if #(.NBYTES(NB), .DEPTH(DP)) fdi ();

  ucie_ctl_rx_fdi_fifo #(.NBYTES(NB), .DEPTH(DP)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .fdi   (fdi)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: queue contents, link mode, sticky flag, credit.
  logic [W-1:0] mq[$];
  int           m_mode = M_IDLE;
  bit           m_ovf = 1'b0;
  bit           m_credit = 1'b0;

  typedef struct {
    logic [3:0]   req;
    bit           v;
    logic [W-1:0] d;
    bit           rdy;
    bit           e_valid;
    logic [W-1:0] e_data;
    int           e_count;
    bit           e_credit;
    bit           e_ovf;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    return (mq.size() != 0) && (m_mode == M_ACT || m_mode == M_DRAIN);
  endfunction

  // Behavioural model of one clock edge.
  task automatic model_edge(input bit r, input logic [3:0] req, input bit v,
                            input logic [W-1:0] d, input bit rdy);
    bit vld, pop, push, ovf_evt;
    int old;
    if (r) begin
      mq.delete();
      m_mode = M_IDLE;
      m_ovf = 1'b0;
      m_credit = 1'b0;
      return;
    end
    old     = m_mode;
    vld     = m_valid();
    pop     = vld && rdy;
    push    = v && (old == M_ACT);
    ovf_evt = push && (mq.size() == DP) && !pop;
    m_credit = pop;
    if (pop) void'(mq.pop_front());
    if (ovf_evt) begin
      mq.delete();
      m_ovf  = 1'b1;
      m_mode = M_ERR;
    end else begin
      if (push) mq.push_back(d);
      case (old)
        M_IDLE:  if (req == 4'h1) m_mode = M_ACT;
        M_ACT:   if (req != 4'h1) m_mode = (mq.size() != 0) ? M_DRAIN : M_IDLE;
        M_DRAIN: if (req == 4'h1) m_mode = M_ACT;
                 else if (mq.size() == 0) m_mode = M_IDLE;
        M_ERR:   if (req == 4'h0) begin m_mode = M_IDLE; m_ovf = 1'b0; end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // Drive one cycle of inputs, advance model and DUT, compare outputs.
  task automatic step(input bit r, input logic [3:0] req, input bit v,
                      input logic [W-1:0] d, input bit rdy);
    @(negedge clk);
    rst                  = r;
    fdi.i_state_request  = req;
    fdi.i_fdi_data_valid = v;
    fdi.i_fdi_data       = d;
    fdi.i_pl_ready       = rdy;
    @(posedge clk);
    model_edge(r, req, v, d, rdy);
    #1;
    chk("m_valid",  64'(fdi.o_pl_valid),      64'(m_valid()));
    chk("m_count",  64'(fdi.o_count),         64'(mq.size()));
    chk("m_credit", 64'(fdi.o_credit_return), 64'(m_credit));
    chk("m_ovf",    64'(fdi.o_overflow),      64'(m_ovf));
    if (m_valid()) chk("m_data", 64'(fdi.o_pl_data), 64'(mq[0]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int credits;
    int pushed;
    int budget;

    // req, v, d, rdy | valid, data, count, credit, ovf
    tbl[0]  = '{4'h1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  0, 1'b0, 1'b0};
    tbl[1]  = '{4'h1, 1'b1, 32'hA1, 1'b1, 1'b1, 32'hA1, 1, 1'b0, 1'b0};
    tbl[2]  = '{4'h1, 1'b1, 32'hA2, 1'b1, 1'b1, 32'hA2, 1, 1'b1, 1'b0};
    tbl[3]  = '{4'h1, 1'b1, 32'hA3, 1'b1, 1'b1, 32'hA3, 1, 1'b1, 1'b0};
    tbl[4]  = '{4'h1, 1'b1, 32'hA4, 1'b1, 1'b1, 32'hA4, 1, 1'b1, 1'b0};
    tbl[5]  = '{4'h1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  0, 1'b1, 1'b0};
    tbl[6]  = '{4'h1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  0, 1'b0, 1'b0};
    tbl[7]  = '{4'h1, 1'b1, 32'hB1, 1'b0, 1'b1, 32'hB1, 1, 1'b0, 1'b0};
    tbl[8]  = '{4'h1, 1'b1, 32'hB2, 1'b0, 1'b1, 32'hB1, 2, 1'b0, 1'b0};
    tbl[9]  = '{4'h1, 1'b1, 32'hB3, 1'b0, 1'b1, 32'hB1, 3, 1'b0, 1'b0};
    tbl[10] = '{4'h1, 1'b1, 32'hB4, 1'b0, 1'b1, 32'hB1, 4, 1'b0, 1'b0};
    tbl[11] = '{4'h1, 1'b1, 32'hB5, 1'b0, 1'b0, 32'h0,  0, 1'b0, 1'b1};
    tbl[12] = '{4'h1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  0, 1'b0, 1'b1};
    tbl[13] = '{4'h0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  0, 1'b0, 1'b0};
    tbl[14] = '{4'h1, 1'b1, 32'hC1, 1'b1, 1'b0, 32'h0,  0, 1'b0, 1'b0};

    rst = 1'b1;
    fdi.i_state_request  = 4'h0;
    fdi.i_fdi_data_valid = 1'b0;
    fdi.i_fdi_data       = '0;
    fdi.i_pl_ready       = 1'b0;

    // Reset values
    step(1'b1, 4'h0, 1'b0, '0, 1'b0);
    step(1'b1, 4'h1, 1'b1, 32'hDEAD, 1'b1);
    chk("rst_valid",  64'(fdi.o_pl_valid),      64'd0);
    chk("rst_count",  64'(fdi.o_count),         64'd0);
    chk("rst_credit", 64'(fdi.o_credit_return), 64'd0);
    chk("rst_ovf",    64'(fdi.o_overflow),      64'd0);

    // Basic flow, back-pressure to overflow, ERROR exit, IDLE drops writes
    for (int i = 0; i < 15; i++) begin
      step(1'b0, tbl[i].req, tbl[i].v, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i),  64'(fdi.o_pl_valid),      64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_count", i),  64'(fdi.o_count),         64'(tbl[i].e_count));
      chk($sformatf("tbl%0d_credit", i), 64'(fdi.o_credit_return), 64'(tbl[i].e_credit));
      chk($sformatf("tbl%0d_ovf", i),    64'(fdi.o_overflow),      64'(tbl[i].e_ovf));
      if (tbl[i].e_valid)
        chk($sformatf("tbl%0d_data", i), 64'(fdi.o_pl_data), 64'(tbl[i].e_data));
    end

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) step(1'b0, 4'h1, 1'b1, 32'hD0 + W'(i), 1'b0);
    chk("full_count", 64'(fdi.o_count), 64'd4);
    step(1'b0, 4'h1, 1'b1, 32'hD4, 1'b1);
    chk("fullpp_count", 64'(fdi.o_count),    64'd4);
    chk("fullpp_ovf",   64'(fdi.o_overflow), 64'd0);
    chk("fullpp_data",  64'(fdi.o_pl_data),  64'hD1);
    for (int i = 0; i < 5; i++) step(1'b0, 4'h1, 1'b0, '0, 1'b1);
    chk("fullpp_empty", 64'(fdi.o_count), 64'd0);

    // Drain on exit from Active
    for (int i = 0; i < 3; i++) step(1'b0, 4'h1, 1'b1, 32'hE0 + W'(i), 1'b0);
    step(1'b0, 4'h4, 1'b0, '0, 1'b0);
    chk("drain_count", 64'(fdi.o_count),    64'd3);
    chk("drain_valid", 64'(fdi.o_pl_valid), 64'd1);
    step(1'b0, 4'h4, 1'b1, 32'hEE, 1'b0);
    step(1'b0, 4'h4, 1'b1, 32'hEF, 1'b0);
    chk("drain_drop", 64'(fdi.o_count), 64'd3);
    budget = 0;
    while (mq.size() != 0 && budget < 10) begin
      step(1'b0, 4'h4, 1'b1, 32'hF0, 1'b1);
      budget++;
    end
    if (mq.size() != 0) chk("drain_budget", 64'd0, 64'd1);
    step(1'b0, 4'h4, 1'b1, 32'hF1, 1'b1);
    chk("drain_idle_count", 64'(fdi.o_count),    64'd0);
    chk("drain_idle_valid", 64'(fdi.o_pl_valid), 64'd0);

    // Wrap-around with random ready
    step(1'b0, 4'h1, 1'b0, '0, 1'b0);
    credits = 0;
    pushed  = 0;
    budget  = 0;
    while ((pushed < 10 || mq.size() != 0) && budget < 200) begin
      if (pushed < 10 && mq.size() < DP) begin
        step(1'b0, 4'h1, 1'b1, W'($urandom), 1'($urandom_range(0, 1)));
        pushed++;
      end else begin
        step(1'b0, 4'h1, 1'b0, '0, 1'($urandom_range(0, 1)));
      end
      credits += int'(fdi.o_credit_return);
      budget++;
    end
    if (pushed < 10 || mq.size() != 0) chk("wrap_budget", 64'd0, 64'd1);
    step(1'b0, 4'h1, 1'b0, '0, 1'b1);
    credits += int'(fdi.o_credit_return);
    chk("wrap_credits", 64'(credits), 64'd10);

    // Reset mid-stream
    step(1'b0, 4'h1, 1'b1, 32'h11, 1'b0);
    step(1'b0, 4'h1, 1'b1, 32'h22, 1'b0);
    chk("mid_count", 64'(fdi.o_count), 64'd2);
    step(1'b1, 4'h1, 1'b0, '0, 1'b1);
    chk("midrst_valid",  64'(fdi.o_pl_valid),      64'd0);
    chk("midrst_count",  64'(fdi.o_count),         64'd0);
    chk("midrst_credit", 64'(fdi.o_credit_return), 64'd0);
    step(1'b0, 4'h1, 1'b0, '0, 1'b1);
    chk("midrst_credit2", 64'(fdi.o_credit_return), 64'd0);
    step(1'b0, 4'h1, 1'b1, 32'h55, 1'b0);
    chk("resume_valid", 64'(fdi.o_pl_valid), 64'd1);
    chk("resume_data",  64'(fdi.o_pl_data),  64'h55);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int unsigned rq;
      logic [3:0] req;
      bit rdy;
      rq  = $urandom_range(0, 19);
      req = (rq < 16) ? 4'h1 : (rq < 18) ? 4'h4 : 4'h0;
      rdy = ((i % 100) < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 99) == 0), req, 1'($urandom_range(0, 1)), W'($urandom), rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
